// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU decoder/executor with iterative multu/divu and HI/LO.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func_field,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       alu_ctrl,
    output logic             reg_write,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_op;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dz;

    logic w_rtype, w_add, w_sub, w_and, w_or, w_slt, w_mfhi, w_mflo, w_multu, w_divu;
    logic w_addi, w_lw, w_sw, w_beq, w_writer, w_start, w_slt_bit;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_next_hi;
    logic [WIDTH-1:0] w_next_lo;

    assign w_rtype = (opcode == 6'b000000);
    assign w_add   = w_rtype & (func_field == 6'b100000);
    assign w_sub   = w_rtype & (func_field == 6'b100010);
    assign w_and   = w_rtype & (func_field == 6'b100100);
    assign w_or    = w_rtype & (func_field == 6'b100101);
    assign w_slt   = w_rtype & (func_field == 6'b101010);
    assign w_mfhi  = w_rtype & (func_field == 6'b010000);
    assign w_mflo  = w_rtype & (func_field == 6'b010010);
    assign w_multu = w_rtype & (func_field == 6'b011001);
    assign w_divu  = w_rtype & (func_field == 6'b011011);
    assign w_addi  = (opcode == 6'b001000);
    assign w_lw    = (opcode == 6'b100011);
    assign w_sw    = (opcode == 6'b101011);
    assign w_beq   = (opcode == 6'b000100);

    assign w_writer = w_add | w_sub | w_and | w_or | w_slt | w_mfhi | w_mflo | w_addi | w_lw;

    always_comb begin
        alu_ctrl = 3'b000;
        if (w_add | w_addi | w_lw | w_sw) alu_ctrl = 3'b010;
        else if (w_sub | w_beq)           alu_ctrl = 3'b110;
        else if (w_or)                    alu_ctrl = 3'b001;
        else if (w_slt)                   alu_ctrl = 3'b111;
        else if (w_mfhi | w_mflo)         alu_ctrl = 3'b011;
        else if (w_multu | w_divu)        alu_ctrl = 3'b100;
    end

    assign w_slt_bit = ($signed(a) < $signed(b));

    always_comb begin
        result = '0;
        case (alu_ctrl)
            3'b010:  result = a + b;
            3'b110:  result = a - b;
            3'b000:  result = a & b;
            3'b001:  result = a | b;
            3'b111:  result = {{(WIDTH-1){1'b0}}, w_slt_bit};
            3'b011:  result = w_mfhi ? r_hi : r_lo;
            default: result = '0;
        endcase
    end

    assign zero        = (result == '0);
    assign busy        = (r_state == S_MUL) || (r_state == S_DIV);
    assign done        = (r_state == S_DONE);
    assign div_by_zero = done & r_dz;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign stall       = busy & valid & (w_mfhi | w_mflo | w_multu | w_divu);
    assign reg_write   = valid & ~stall & w_writer;
    assign w_start     = valid & (w_multu | w_divu) & ((r_state == S_IDLE) || (r_state == S_DONE));

    // MUL: {acc_hi, acc_lo} shifts right, acc_lo starts as multiplier.
    // DIV: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_op} : '0);
    assign w_rem_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_op};

    always_comb begin
        w_next_hi = r_acc_hi;
        w_next_lo = r_acc_lo;
        if (r_state == S_MUL) begin
            w_next_hi = w_mul_sum[WIDTH:1];
            w_next_lo = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
        end else if (!w_diff[WIDTH]) begin
            w_next_hi = w_diff[WIDTH-1:0];
            w_next_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            w_next_hi = w_rem_shift[WIDTH-1:0];
            w_next_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_op     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                S_MUL, S_DIV: begin
                    r_acc_hi <= w_next_hi;
                    r_acc_lo <= w_next_lo;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_hi    <= w_next_hi;
                        r_lo    <= w_next_lo;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    if (w_start) begin
                        r_state  <= w_multu ? S_MUL : S_DIV;
                        r_cnt    <= '0;
                        r_op     <= w_multu ? a : b;
                        r_acc_lo <= w_multu ? b : a;
                        r_acc_hi <= '0;
                        r_dz     <= w_divu & (b == '0);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit at WIDTH=8.
module tb_alu_exec_unit;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic [5:0]   opcode, func_field;
    logic [W-1:0] a, b;
    logic [2:0]   alu_ctrl;
    logic         reg_write, zero, busy, done, div_by_zero, stall;
    logic [W-1:0] result, hi, lo;

    int total = 0;
    int bad   = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .opcode(opcode), .func_field(func_field),
        .a(a), .b(b), .alu_ctrl(alu_ctrl), .reg_write(reg_write), .result(result), .zero(zero),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [5:0] op;
        logic [5:0] fn;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] ctrl;
        logic [7:0] res;
        logic       rw;
        logic       z;
    } vec_t;

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [7:0] aa, input logic [7:0] bb);
        valid = v; opcode = op; func_field = fn; a = aa; b = bb;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 6'h00, 6'h00, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({busy, done, div_by_zero, stall, hi, lo} !== 20'h0) begin
            bad++;
            $display("FAIL reset_state got busy=%b done=%b dz=%b stall=%b hi=%h lo=%h exp all zero",
                     busy, done, div_by_zero, stall, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        vec_t vecs [17];
        vecs = '{
            '{1'b1, 6'h00, 6'h20, 8'h05, 8'h03, 3'b010, 8'h08, 1'b1, 1'b0},
            '{1'b1, 6'h00, 6'h22, 8'h03, 8'h03, 3'b110, 8'h00, 1'b1, 1'b1},
            '{1'b1, 6'h00, 6'h24, 8'h0C, 8'h0A, 3'b000, 8'h08, 1'b1, 1'b0},
            '{1'b1, 6'h00, 6'h25, 8'h0C, 8'h0A, 3'b001, 8'h0E, 1'b1, 1'b0},
            '{1'b1, 6'h00, 6'h2A, 8'hFF, 8'h01, 3'b111, 8'h01, 1'b1, 1'b0},
            '{1'b1, 6'h00, 6'h2A, 8'h01, 8'hFF, 3'b111, 8'h00, 1'b1, 1'b1},
            '{1'b1, 6'h00, 6'h22, 8'h00, 8'h01, 3'b110, 8'hFF, 1'b1, 1'b0},
            '{1'b1, 6'h00, 6'h20, 8'hFF, 8'h01, 3'b010, 8'h00, 1'b1, 1'b1},
            '{1'b1, 6'h08, 6'h3F, 8'h7F, 8'h01, 3'b010, 8'h80, 1'b1, 1'b0},
            '{1'b1, 6'h23, 6'h00, 8'h10, 8'h04, 3'b010, 8'h14, 1'b1, 1'b0},
            '{1'b1, 6'h2B, 6'h00, 8'h10, 8'h04, 3'b010, 8'h14, 1'b0, 1'b0},
            '{1'b1, 6'h04, 6'h00, 8'h05, 8'h05, 3'b110, 8'h00, 1'b0, 1'b1},
            '{1'b1, 6'h3F, 6'h20, 8'h0C, 8'h0A, 3'b000, 8'h08, 1'b0, 1'b0},
            '{1'b1, 6'h00, 6'h3F, 8'h0C, 8'h0A, 3'b000, 8'h08, 1'b0, 1'b0},
            '{1'b0, 6'h00, 6'h20, 8'h05, 8'h03, 3'b010, 8'h08, 1'b0, 1'b0},
            '{1'b1, 6'h00, 6'h10, 8'h33, 8'h44, 3'b011, 8'h00, 1'b1, 1'b1},
            '{1'b1, 6'h00, 6'h1B, 8'h33, 8'h44, 3'b100, 8'h00, 1'b0, 1'b1}
        };
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b);
            #1;
            total++;
            if ({alu_ctrl, result, reg_write, zero, stall} !==
                {vecs[i].ctrl, vecs[i].res, vecs[i].rw, vecs[i].z, 1'b0}) begin
                bad++;
                $display("FAIL decode[%0d] got ctrl=%b res=%h rw=%b z=%b stall=%b exp ctrl=%b res=%h rw=%b z=%b stall=0",
                         i, alu_ctrl, result, reg_write, zero, stall,
                         vecs[i].ctrl, vecs[i].res, vecs[i].rw, vecs[i].z);
            end
        end
        @(negedge clk);
        drive(1'b0, 6'h00, 6'h00, 8'h00, 8'h00);
    endtask

    task automatic test_multu();
        @(negedge clk);
        drive(1'b1, 6'h00, 6'h19, 8'd200, 8'd3);
        #1;
        total++;
        if ({alu_ctrl, reg_write, stall, busy} !== {3'b100, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL multu_issue got ctrl=%b rw=%b stall=%b busy=%b exp 100 0 0 0",
                     alu_ctrl, reg_write, stall, busy);
        end
        @(negedge clk);
        drive(1'b0, 6'h00, 6'h00, 8'h00, 8'h00);
        for (int i = 1; i <= W; i++) begin
            #1;
            total++;
            if ({busy, done} !== 2'b10) begin
                bad++;
                $display("FAIL multu_busy cycle %0d got busy=%b done=%b exp 1 0", i, busy, done);
            end
            @(negedge clk);
        end
        #1;
        total++;
        if ({busy, done, div_by_zero, hi, lo} !== {3'b010, 8'h02, 8'h58}) begin
            bad++;
            $display("FAIL multu_done got busy=%b done=%b dz=%b hi=%h lo=%h exp 0 1 0 02 58",
                     busy, done, div_by_zero, hi, lo);
        end
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL multu_done_pulse got done=%b exp 0", done);
        end
    endtask

    task automatic test_divu();
        @(negedge clk);
        drive(1'b1, 6'h00, 6'h1B, 8'd100, 8'd7);
        @(negedge clk);
        drive(1'b0, 6'h00, 6'h00, 8'h00, 8'h00);
        repeat (W) @(negedge clk);
        #1;
        total++;
        if ({done, div_by_zero, hi, lo} !== {2'b10, 8'd2, 8'd14}) begin
            bad++;
            $display("FAIL divu_done got done=%b dz=%b hi=%0d lo=%0d exp 1 0 2 14",
                     done, div_by_zero, hi, lo);
        end
        @(negedge clk);
        drive(1'b1, 6'h00, 6'h12, 8'h00, 8'h00);
        #1;
        total++;
        if ({alu_ctrl, result, reg_write, stall} !== {3'b011, 8'd14, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL mflo_read got ctrl=%b res=%0d rw=%b stall=%b exp 011 14 1 0",
                     alu_ctrl, result, reg_write, stall);
        end
    endtask

    task automatic test_divu_zero();
        @(negedge clk);
        drive(1'b1, 6'h00, 6'h1B, 8'h5A, 8'h00);
        @(negedge clk);
        drive(1'b0, 6'h00, 6'h00, 8'h00, 8'h00);
        repeat (W - 1) @(negedge clk);
        #1;
        total++;
        if ({busy, done, div_by_zero} !== 3'b100) begin
            bad++;
            $display("FAIL divz_full_iter got busy=%b done=%b dz=%b exp 1 0 0", busy, done, div_by_zero);
        end
        @(negedge clk);
        #1;
        total++;
        if ({done, div_by_zero, hi, lo} !== {2'b11, 8'h5A, 8'hFF}) begin
            bad++;
            $display("FAIL divz_done got done=%b dz=%b hi=%h lo=%h exp 1 1 5a ff",
                     done, div_by_zero, hi, lo);
        end
        @(negedge clk);
        #1;
        total++;
        if (div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL divz_pulse got dz=%b exp 0", div_by_zero);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        drive(1'b1, 6'h00, 6'h19, 8'h10, 8'h11);
        @(negedge clk);
        drive(1'b1, 6'h00, 6'h10, 8'h00, 8'h00);
        #1;
        total++;
        if ({stall, reg_write} !== 2'b10) begin
            bad++;
            $display("FAIL mfhi_stall c1 got stall=%b rw=%b exp 1 0", stall, reg_write);
        end
        @(negedge clk);
        drive(1'b1, 6'h00, 6'h20, 8'h01, 8'h02);
        #1;
        total++;
        if ({busy, stall, reg_write, result} !== {3'b101, 8'h03}) begin
            bad++;
            $display("FAIL add_while_busy got busy=%b stall=%b rw=%b res=%h exp 1 0 1 03",
                     busy, stall, reg_write, result);
        end
        for (int i = 3; i <= W; i++) begin
            @(negedge clk);
            drive(1'b1, 6'h00, 6'h10, 8'h00, 8'h00);
            #1;
            total++;
            if ({stall, reg_write} !== 2'b10) begin
                bad++;
                $display("FAIL mfhi_stall c%0d got stall=%b rw=%b exp 1 0", i, stall, reg_write);
            end
        end
        @(negedge clk);
        #1;
        total++;
        if ({done, stall, reg_write, result} !== {3'b101, 8'h01}) begin
            bad++;
            $display("FAIL mfhi_in_done got done=%b stall=%b rw=%b res=%h exp 1 0 1 01",
                     done, stall, reg_write, result);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(1'b1, 6'h00, 6'h19, 8'h0F, 8'h03);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            drive(1'b1, 6'h00, 6'h19, 8'h02, 8'h03);
            #1;
            total++;
            if ({busy, stall, reg_write} !== 3'b110) begin
                bad++;
                $display("FAIL multu_held c%0d got busy=%b stall=%b rw=%b exp 1 1 0",
                         i, busy, stall, reg_write);
            end
        end
        @(negedge clk);
        #1;
        total++;
        if ({done, stall, hi, lo} !== {2'b10, 8'h00, 8'h2D}) begin
            bad++;
            $display("FAIL b2b_first_done got done=%b stall=%b hi=%h lo=%h exp 1 0 00 2d",
                     done, stall, hi, lo);
        end
        @(negedge clk);
        drive(1'b0, 6'h00, 6'h00, 8'h00, 8'h00);
        #1;
        total++;
        if ({busy, done} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_accept got busy=%b done=%b exp 1 0", busy, done);
        end
        repeat (W) @(negedge clk);
        #1;
        total++;
        if ({done, hi, lo} !== {1'b1, 8'h00, 8'h06}) begin
            bad++;
            $display("FAIL b2b_second_done got done=%b hi=%h lo=%h exp 1 00 06", done, hi, lo);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(1'b1, 6'h00, 6'h1B, 8'd100, 8'd7);
        @(negedge clk);
        drive(1'b0, 6'h00, 6'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, div_by_zero, hi, lo} !== 19'h0) begin
            bad++;
            $display("FAIL async_reset got busy=%b done=%b dz=%b hi=%h lo=%h exp all zero",
                     busy, done, div_by_zero, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 6'h00, 6'h19, 8'd15, 8'd15);
        #1;
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL post_reset_idle got busy=%b done=%b exp 0 0", busy, done);
        end
        @(negedge clk);
        drive(1'b0, 6'h00, 6'h00, 8'h00, 8'h00);
        repeat (W) @(negedge clk);
        #1;
        total++;
        if ({done, hi, lo} !== {1'b1, 8'h00, 8'hE1}) begin
            bad++;
            $display("FAIL post_reset_multu got done=%b hi=%h lo=%h exp 1 00 e1", done, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_multu();
        test_divu();
        test_divu_zero();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
